// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// Provides the FSM state enum, the slice width and slice/index sizing.
package nibble_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam int unsigned SLICE_W = 4;

   function automatic int unsigned calc_nslice(int unsigned w);
      return w / SLICE_W;
   endfunction

   // A single-slice build still needs a 1-bit index register.
   function automatic int unsigned calc_idx_w(int unsigned w);
      int unsigned n;
      n = w / SLICE_W;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Combinational 4-bit ripple slice: {co_o,s_o} = a_i + b_i + ci_i.
// Ports: a_i, b_i nibble operands; ci_i carry in; s_o nibble sum; co_o carry out.
module nibble_adder_slice
   import nibble_serial_adder_ctrl_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               ci_i,
   output logic [SLICE_W-1:0] s_o,
   output logic               co_o
);

   assign {co_o, s_o} = {1'b0, a_i}
                      + {1'b0, b_i}
                      + {{SLICE_W{1'b0}}, ci_i};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles.
// Ports: clk/rst; in_valid/in_ready + a,b,cin; out_valid/out_ready + sum,cout; busy.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int unsigned NSLICE = calc_nslice(WIDTH);
   localparam int unsigned IDX_W  = calc_idx_w(WIDTH);

   // Operands viewed as an array of nibbles so idx selects a slice directly.
   typedef logic [NSLICE-1:0][SLICE_W-1:0] word_t;

   state_e           state_q, state_d;
   word_t            a_q, a_d;
   word_t            b_q, b_d;
   word_t            sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [SLICE_W-1:0] s_sum;
   logic               s_co;

   nibble_adder_slice u_slice (
      .a_i  (a_q[idx_q]),
      .b_i  (b_q[idx_q]),
      .ci_i (carry_q),
      .s_o  (s_sum),
      .co_o (s_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q] = s_sum;
            carry_d      = s_co;
            // Last pass holds idx so it never wraps.
            if (idx_q == IDX_W'(NSLICE - 1)) begin
               cout_d  = s_co;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
